// File: rtl/unpacked_deserializer_pkg.sv
// Shared helpers for the narrow-to-wide unpacked stream converter.
// Width of the beat counter, never below one bit.
package unpacked_deserializer_pkg;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unpacked_deserializer.sv
// Collects OUT_SIZE/IN_SIZE input beats into one registered output vector.
// Input is stalled only while a completed vector is held by back-pressure.
module unpacked_deserializer
    import unpacked_deserializer_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  IN_SIZE    = 4,
    parameter int  OUT_SIZE   = 16,
    parameter type MYDATA     = logic [DATA_WIDTH-1:0]
) (
    input  logic  clk,
    input  logic  rst,
    input  MYDATA in_data [IN_SIZE-1:0],
    input  logic  in_valid,
    output logic  in_ready,
    output MYDATA out_data [OUT_SIZE-1:0],
    output logic  out_valid,
    input  logic  out_ready
);

    localparam int NUM_BEATS = OUT_SIZE / IN_SIZE;
    localparam int CNT_W     = cnt_width(NUM_BEATS);

    if (OUT_SIZE % IN_SIZE != 0) begin : g_size_check
        $error("OUT_SIZE must be an integer multiple of IN_SIZE");
    end

    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 last;
    logic [NUM_BEATS-1:0] beat_we;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(NUM_BEATS - 1));

    // One write-enable per slot group, selected by the beat counter
    for (genvar k = 0; k < NUM_BEATS; k++) begin : g_we
        assign beat_we[k] = accept && (cnt == CNT_W'(k));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            for (int j = 0; j < OUT_SIZE; j++) begin
                out_data[j] <= '0;
            end
        end else begin
            if (accept) begin
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            // A final beat on the same edge as a handshake keeps valid high
            if (accept && last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            for (int k = 0; k < NUM_BEATS; k++) begin
                if (beat_we[k]) begin
                    for (int i = 0; i < IN_SIZE; i++) begin
                        out_data[k*IN_SIZE+i] <= in_data[i];
                    end
                end
            end
        end
    end

endmodule
